seq_lut_loader: RTL and testbench

//  Host-side writer for the sequencer command LUT. Accepts a byte stream (valid/ready) from the host bridge.

---
 rtl/seq_lut_pkg.sv | 59 +++++
 rtl/seq_lut_entry_assembler.sv | 51 +++++
 rtl/seq_lut_loader.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_seq_lut_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_lut_pkg.sv
// seq_lut_pkg: shared definitions for the sequencer command LUT loader.
//   - field LSB/width localparams of a 37-bit LUT entry
//   - lut_entry_t    packed view of one entry
//   - loader_state_e loader FSM encoding
//   - err_code_e     values reported on error_code_o
//   - checksum_add   32-bit wrap-around accumulation of a 29-bit LUT word
package seq_lut_pkg;

   localparam int ENTRY_W      = 37;
   localparam int ENTRY_BYTES  = 5;
   localparam int STATE_LSB    = 0;
   localparam int STATE_W      = 3;
   localparam int REPEAT_LSB   = 3;
   localparam int REPEAT_W     = 8;
   localparam int LENGTH_LSB   = 11;
   localparam int LENGTH_W     = 16;
   localparam int EOF_BIT      = 27;
   localparam int SOF_BIT      = 28;
   localparam int NEXT_LSB     = 29;
   localparam int NEXT_W       = 8;
   localparam int READBACK_W   = 29;

   typedef struct packed {
      logic [NEXT_W-1:0]   next_addr;
      logic                sof;
      logic                eof;
      logic [LENGTH_W-1:0] length;
      logic [REPEAT_W-1:0] rpt;
      logic [STATE_W-1:0]  state;
   } lut_entry_t;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_COLLECT = 4'd1,
      ST_WRITE   = 4'd2,
      ST_REWIND  = 4'd3,
      ST_READ    = 4'd4,
      ST_DRAIN   = 4'd5,
      ST_FINISH  = 4'd6,
      ST_DONE    = 4'd7,
      ST_ERROR   = 4'd8
   } loader_state_e;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_RESERVED  = 3'd1,
      ERR_TIMEOUT   = 3'd2,
      ERR_VERIFY    = 3'd3,
      ERR_NEXT_ADDR = 3'd4,
      ERR_COUNT     = 3'd5
   } err_code_e;

   // Checksum over the readback-visible part of an entry, modulo 2^32.
   function automatic logic [31:0] checksum_add(input logic [31:0] sum,
                                                input logic [READBACK_W-1:0] word);
      return sum + {3'b000, word};
   endfunction

endpackage

// File: rtl/seq_lut_entry_assembler.sv
// seq_lut_entry_assembler: collects 5 little-endian host bytes into one LUT entry.
// The fifth byte is combined combinationally so the loader can decide and write
// on the very edge that accepts it (5 accept cycles + 1 write cycle per entry).
// Ports:
//   clk, reset_i      clock, asynchronous active-high reset
//   clear_i           drop any partial entry (new load accepted)
//   byte_fire_i       byte_data_i is transferred this cycle
//   byte_data_i       host byte
//   entry_valid_o     fifth byte of an entry transferred this cycle
//   entry_o           assembled entry, meaningful while entry_valid_o
//   rsvd_err_o        fifth byte has nonzero bits [7:5]
module seq_lut_entry_assembler
   import seq_lut_pkg::*;
(
   input  logic       clk,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic       byte_fire_i,
   input  logic [7:0] byte_data_i,
   output logic       entry_valid_o,
   output lut_entry_t entry_o,
   output logic       rsvd_err_o
);

   logic [2:0]  byte_cnt_r;
   logic [31:0] shift_r;
   logic [39:0] assembled_s;

   // Bytes shift in from the top so byte0 ends up in [7:0] after four transfers.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         byte_cnt_r <= 3'd0;
         shift_r    <= 32'd0;
      end else if (clear_i) begin
         byte_cnt_r <= 3'd0;
         shift_r    <= 32'd0;
      end else if (byte_fire_i) begin
         byte_cnt_r <= (byte_cnt_r == 3'(ENTRY_BYTES - 1)) ? 3'd0 : byte_cnt_r + 3'd1;
         shift_r    <= {byte_data_i, shift_r[31:8]};
      end else begin
         byte_cnt_r <= byte_cnt_r;
         shift_r    <= shift_r;
      end
   end

   assign assembled_s   = {byte_data_i, shift_r};
   assign entry_valid_o = byte_fire_i && (byte_cnt_r == 3'(ENTRY_BYTES - 1));
   assign entry_o       = assembled_s[ENTRY_W-1:0];
   assign rsvd_err_o    = entry_valid_o && (assembled_s[39:ENTRY_W] != 3'b000);

endmodule

// File: rtl/seq_lut_loader.sv
// seq_lut_loader: host-side writer for the sequencer command LUT.
// Takes a valid/ready byte stream, assembles 37-bit entries, validates them,
// writes them to the sequencer and raises config_done_o once the table is in.
// Build option: define SEQ_LUT_VERIFY_EN to read the table back after loading
// and compare a 32-bit checksum of the written and read words.
// Ports:
//   clk, reset_i              clock, asynchronous active-high reset
//   start_i, entry_count_i    start a load of entry_count_i entries (1..LUT_DEPTH)
//   byte_data_i/valid/ready   host byte stream, transfer when valid && ready
//   lut_wen_o/write_data_o    LUT write port, one strobe per entry
//   lut_rden_o/read_data_i    LUT readback (verify builds only)
//   seq_reset_o               rewinds the sequencer LUT address (verify builds only)
//   config_done_o, busy_o     table loaded / load in progress
//   done_o                    one-cycle pulse on success
//   error_o, error_code_o     sticky error and its cause until next accepted start
//   entries_written_o         write strobes issued in the current load
module seq_lut_loader
   import seq_lut_pkg::*;
#(
   parameter int BYTE_TIMEOUT = 1000,
   parameter int LUT_DEPTH    = 256
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [8:0]            entry_count_i,
   input  logic [7:0]            byte_data_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  lut_wen_o,
   output logic [ENTRY_W-1:0]    lut_write_data_o,
   output logic                  lut_rden_o,
   input  logic [READBACK_W-1:0] lut_read_data_i,
   output logic                  seq_reset_o,
   output logic                  config_done_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [2:0]            error_code_o,
   output logic [8:0]            entries_written_o
);

   localparam int TMR_W = $clog2(BYTE_TIMEOUT + 1);

   loader_state_e    state_r, state_nxt_s;
   err_code_e        err_det_s, err_code_r, err_code_nxt_s;
   logic             start_acc_s, byte_fire_s, entry_valid_s, rsvd_err_s;
   lut_entry_t       entry_s, lut_data_r;
   logic [8:0]       count_r, entries_written_r;
   logic [TMR_W-1:0] idle_cnt_r;
   logic byte_ready_r, lut_wen_r, config_done_r, busy_r, done_r, error_r;
   logic byte_ready_nxt_s, lut_wen_nxt_s, config_done_nxt_s, busy_nxt_s, done_nxt_s, error_nxt_s;

   assign start_acc_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
   assign byte_fire_s = byte_valid_i && byte_ready_r;

   seq_lut_entry_assembler u_asm (
      .clk           (clk),
      .reset_i       (reset_i),
      .clear_i       (start_acc_s),
      .byte_fire_i   (byte_fire_s),
      .byte_data_i   (byte_data_i),
      .entry_valid_o (entry_valid_s),
      .entry_o       (entry_s),
      .rsvd_err_o    (rsvd_err_s)
   );

`ifdef SEQ_LUT_VERIFY_EN
   logic        lut_rden_r, seq_reset_r, rden_q_r, lut_rden_nxt_s, seq_reset_nxt_s;
   logic [8:0]  read_cnt_r;
   logic [31:0] sum_w_r, sum_r_r, sum_final_s;

   // Final readback word arrives during DRAIN and is folded in before comparing.
   assign sum_final_s = checksum_add(sum_r_r, lut_read_data_i);
`endif

   // Next-state logic; err_det_s names the cause whenever the FSM enters ERROR.
   always_comb begin
      state_nxt_s = state_r;
      err_det_s   = ERR_NONE;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               if ((entry_count_i == 9'd0) || (entry_count_i > 9'(LUT_DEPTH))) begin
                  state_nxt_s = ST_ERROR;
                  err_det_s   = ERR_COUNT;
               end else begin
                  state_nxt_s = ST_COLLECT;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_COLLECT: begin
            if (entry_valid_s) begin
               if (rsvd_err_s) begin
                  state_nxt_s = ST_ERROR;
                  err_det_s   = ERR_RESERVED;
               end else if ({1'b0, entry_s.next_addr} >= count_r) begin
                  state_nxt_s = ST_ERROR;
                  err_det_s   = ERR_NEXT_ADDR;
               end else begin
                  state_nxt_s = ST_WRITE;
               end
            end else if (!byte_fire_s && (idle_cnt_r == TMR_W'(BYTE_TIMEOUT - 1))) begin
               state_nxt_s = ST_ERROR;
               err_det_s   = ERR_TIMEOUT;
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         ST_WRITE: begin
            if (entries_written_r == count_r) begin
`ifdef SEQ_LUT_VERIFY_EN
               state_nxt_s = ST_REWIND;
`else
               state_nxt_s = ST_FINISH;
`endif
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
`ifdef SEQ_LUT_VERIFY_EN
         ST_REWIND: state_nxt_s = ST_READ;
         ST_READ: begin
            if (read_cnt_r == (count_r - 9'd1)) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (sum_final_s != sum_w_r) begin
               state_nxt_s = ST_ERROR;
               err_det_s   = ERR_VERIFY;
            end else begin
               state_nxt_s = ST_FINISH;
            end
         end
`endif
         ST_FINISH: state_nxt_s = ST_DONE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state so every output is a plain register.
   always_comb begin
      byte_ready_nxt_s = (state_nxt_s == ST_COLLECT);
      lut_wen_nxt_s    = (state_nxt_s == ST_WRITE);
      done_nxt_s       = (state_nxt_s == ST_FINISH);
      busy_nxt_s       = !((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE) ||
                           (state_nxt_s == ST_ERROR));
`ifdef SEQ_LUT_VERIFY_EN
      lut_rden_nxt_s   = (state_nxt_s == ST_READ);
      seq_reset_nxt_s  = (state_nxt_s == ST_REWIND);
`endif
      if (state_nxt_s == ST_FINISH) begin
         config_done_nxt_s = 1'b1;
      end else if (start_acc_s) begin
         config_done_nxt_s = 1'b0;
      end else begin
         config_done_nxt_s = config_done_r;
      end
      // A bad count on the accepting start must win over the clear.
      if (err_det_s != ERR_NONE) begin
         error_nxt_s    = 1'b1;
         err_code_nxt_s = err_det_s;
      end else if (start_acc_s) begin
         error_nxt_s    = 1'b0;
         err_code_nxt_s = ERR_NONE;
      end else begin
         error_nxt_s    = error_r;
         err_code_nxt_s = err_code_r;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_r       <= ST_IDLE;
         byte_ready_r  <= 1'b0;
         lut_wen_r     <= 1'b0;
         config_done_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         error_r       <= 1'b0;
         err_code_r    <= ERR_NONE;
      end else begin
         state_r       <= state_nxt_s;
         byte_ready_r  <= byte_ready_nxt_s;
         lut_wen_r     <= lut_wen_nxt_s;
         config_done_r <= config_done_nxt_s;
         busy_r        <= busy_nxt_s;
         done_r        <= done_nxt_s;
         error_r       <= error_nxt_s;
         err_code_r    <= err_code_nxt_s;
      end
   end

   // Load bookkeeping: count, idle timer, write data and write counter.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         count_r           <= 9'd0;
         idle_cnt_r        <= '0;
         lut_data_r        <= '0;
         entries_written_r <= 9'd0;
      end else begin
         if (start_acc_s) begin
            count_r <= entry_count_i;
         end else begin
            count_r <= count_r;
         end
         // Only cycles spent waiting for a byte in COLLECT count toward the timeout.
         if (start_acc_s || byte_fire_s) begin
            idle_cnt_r <= '0;
         end else if (state_r == ST_COLLECT) begin
            idle_cnt_r <= idle_cnt_r + TMR_W'(1);
         end else begin
            idle_cnt_r <= idle_cnt_r;
         end
         if (start_acc_s) begin
            entries_written_r <= 9'd0;
            lut_data_r        <= lut_data_r;
         end else if (state_nxt_s == ST_WRITE) begin
            entries_written_r <= entries_written_r + 9'd1;
            lut_data_r        <= entry_s;
         end else begin
            entries_written_r <= entries_written_r;
            lut_data_r        <= lut_data_r;
         end
      end
   end

`ifdef SEQ_LUT_VERIFY_EN
   // Readback sequencing and the written/read checksums.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         lut_rden_r  <= 1'b0;
         seq_reset_r <= 1'b0;
         rden_q_r    <= 1'b0;
         read_cnt_r  <= 9'd0;
         sum_w_r     <= 32'd0;
         sum_r_r     <= 32'd0;
      end else begin
         lut_rden_r  <= lut_rden_nxt_s;
         seq_reset_r <= seq_reset_nxt_s;
         rden_q_r    <= lut_rden_r;
         if (state_r == ST_REWIND) begin
            read_cnt_r <= 9'd0;
         end else if (state_r == ST_READ) begin
            read_cnt_r <= read_cnt_r + 9'd1;
         end else begin
            read_cnt_r <= read_cnt_r;
         end
         if (start_acc_s) begin
            sum_w_r <= 32'd0;
         end else if (state_nxt_s == ST_WRITE) begin
            sum_w_r <= checksum_add(sum_w_r, entry_s[READBACK_W-1:0]);
         end else begin
            sum_w_r <= sum_w_r;
         end
         // Read data is valid the cycle after each rden strobe.
         if (start_acc_s) begin
            sum_r_r <= 32'd0;
         end else if (rden_q_r) begin
            sum_r_r <= sum_final_s;
         end else begin
            sum_r_r <= sum_r_r;
         end
      end
   end

   assign lut_rden_o  = lut_rden_r;
   assign seq_reset_o = seq_reset_r;
`else
   logic unused_rd_s;
   assign unused_rd_s = ^lut_read_data_i;
   assign lut_rden_o  = 1'b0;
   assign seq_reset_o = 1'b0;
`endif

   assign byte_ready_o      = byte_ready_r;
   assign lut_wen_o         = lut_wen_r;
   assign lut_write_data_o  = lut_data_r;
   assign config_done_o     = config_done_r;
   assign busy_o            = busy_r;
   assign done_o            = done_r;
   assign error_o           = error_r;
   assign error_code_o      = err_code_r;
   assign entries_written_o = entries_written_r;

endmodule

// File: tb/tb_seq_lut_loader.sv
// tb_seq_lut_loader: directed, table-driven bench for seq_lut_loader with a
// small sequencer LUT model that answers readback requests.
`timescale 1ns/1ps
module tb_seq_lut_loader;

   logic        clk = 1'b0;
   logic        reset_i, start_i, byte_valid_i;
   logic [8:0]  entry_count_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o, lut_wen_o, lut_rden_o, seq_reset_o;
   logic [36:0] lut_write_data_o;
   logic [28:0] lut_read_data_i = 29'd0;
   logic        config_done_o, busy_o, done_o, error_o;
   logic [2:0]  error_code_o;
   logic [8:0]  entries_written_o;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int wen_cnt  = 0;
   int rden_cnt = 0;
   int srst_cnt = 0;
   int cyc_cnt  = 0;

   logic [28:0] model_mem [0:255];
   logic [7:0]  rd_ptr    = 8'd0;
   logic [28:0] flip_mask = 29'd0;

   typedef struct {
      logic [39:0] pkt;       // byte0 in [7:0] .. byte4 in [39:32]
      logic [36:0] exp_data;
   } vec_t;
   vec_t tbl [12];

   always #5 clk = ~clk;

   seq_lut_loader dut (
      .clk               (clk),
      .reset_i           (reset_i),
      .start_i           (start_i),
      .entry_count_i     (entry_count_i),
      .byte_data_i       (byte_data_i),
      .byte_valid_i      (byte_valid_i),
      .byte_ready_o      (byte_ready_o),
      .lut_wen_o         (lut_wen_o),
      .lut_write_data_o  (lut_write_data_o),
      .lut_rden_o        (lut_rden_o),
      .lut_read_data_i   (lut_read_data_i),
      .seq_reset_o       (seq_reset_o),
      .config_done_o     (config_done_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .error_o           (error_o),
      .error_code_o      (error_code_o),
      .entries_written_o (entries_written_o)
   );

   // Strobe counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (lut_wen_o)   wen_cnt++;
      if (lut_rden_o)  rden_cnt++;
      if (seq_reset_o) srst_cnt++;
   end

   // Sequencer LUT model: write address follows the write count, reads replay from a rewound pointer.
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (lut_wen_o) model_mem[entries_written_o[7:0] - 8'd1] <= lut_write_data_o[28:0];
      if (seq_reset_o) rd_ptr <= 8'd0;
      else if (lut_rden_o) begin
         lut_read_data_i <= model_mem[rd_ptr] ^ flip_mask;
         rd_ptr <= rd_ptr + 8'd1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic start_load(input logic [8:0] n);
      start_i = 1'b1; entry_count_i = n;
      tick(1);
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      byte_valid_i = 1'b1; byte_data_i = b;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (byte_ready_o) begin
            @(posedge clk); #1;
            got = 1'b1;
         end
      end
      byte_valid_i = 1'b0;
      if (!got) check("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_entry(input logic [39:0] pkt);
      for (int k = 0; k < 5; k++) send_byte(pkt[k*8 +: 8]);
   endtask

   task automatic wait_flag(input string name, input bit use_err);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (use_err ? error_o : done_o) seen = 1'b1;
      end
      check(name, 64'(seen), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int w0, t0, t1;
      t0 = 0; t1 = 0;
      tbl[0]  = '{40'h0178563412, 37'h0178563412};
      tbl[1]  = '{40'h0178563412, 37'h0178563412};
      tbl[2]  = '{40'h0000000000, 37'h0000000000};
      tbl[3]  = '{40'h00FFFFFFFF, 37'h00FFFFFFFF};
      tbl[4]  = '{40'h017FFFFFFF, 37'h017FFFFFFF};  // next_addr 11 = count-1
      tbl[5]  = '{40'h003CC35AA5, 37'h003CC35AA5};
      tbl[6]  = '{40'h0004030201, 37'h0004030201};
      tbl[7]  = '{40'h011EADBEEF, 37'h011EADBEEF};
      tbl[8]  = '{40'h0000000080, 37'h0000000080};
      tbl[9]  = '{40'h0080000000, 37'h0080000000};
      tbl[10] = '{40'h012A55AA55, 37'h012A55AA55};
      tbl[11] = '{40'h00ABCD1234, 37'h00ABCD1234};

      reset_i = 1'b1; start_i = 1'b0; entry_count_i = 9'd0;
      byte_data_i = 8'd0; byte_valid_i = 1'b0;
      tick(3);
      check("rst_config_done", 64'(config_done_o), 64'd0);
      check("rst_busy",        64'(busy_o),        64'd0);
      check("rst_ready_wen",   64'({byte_ready_o, lut_wen_o, done_o}), 64'd0);
      check("rst_error",       64'({error_o, error_code_o}), 64'd0);
      check("rst_data_count",  64'({lut_write_data_o, entries_written_o}), 64'd0);
      reset_i = 1'b0;
      tick(1);

      // 12-entry load from the table, back-to-back bytes
      w0 = wen_cnt;
      start_load(9'd12);
      check("start_busy", 64'(busy_o), 64'd1);
      for (int i = 0; i < 12; i++) begin
         send_entry(tbl[i].pkt);
         check("tbl_wen",      64'(lut_wen_o), 64'd1);
         check("tbl_ready_lo", 64'(byte_ready_o), 64'd0);
         check("tbl_wdata",    64'(lut_write_data_o), 64'(tbl[i].exp_data));
         check("tbl_nwritten", 64'(entries_written_o), 64'(i + 1));
         if (i == 0)  t0 = cyc_cnt;
         if (i == 11) t1 = cyc_cnt;
      end
      check("tbl_rate", 64'(t1 - t0), 64'd66);
      wait_flag("tbl_done_seen", 1'b0);
      check("tbl_done_pulse", 64'(done_o), 64'd0);
      check("tbl_config_done", 64'(config_done_o), 64'd1);
      check("tbl_busy_idle", 64'({busy_o, error_o}), 64'd0);
      check("tbl_wen_total", 64'(wen_cnt - w0), 64'd12);
      tick(3);
      check("tbl_data_hold", 64'(lut_write_data_o), 64'(tbl[11].exp_data));

      // start while busy is ignored
      w0 = wen_cnt;
      start_load(9'd3);
      check("rerun_clears_done", 64'(config_done_o), 64'd0);
      send_entry(tbl[2].pkt);
      start_load(9'd0);
      check("busy_start_ignored", 64'({busy_o, error_o}), 64'b10);
      send_entry(tbl[6].pkt);
      send_entry(tbl[8].pkt);
      wait_flag("busy_done_seen", 1'b0);
      check("busy_written", 64'(entries_written_o), 64'd3);
      check("busy_wen_total", 64'(wen_cnt - w0), 64'd3);

      // reserved bits in byte4
      w0 = wen_cnt;
      start_load(9'd12);
      send_entry(40'hE178563412);
      check("rsvd_error", 64'({error_o, error_code_o}), 64'({1'b1, 3'd1}));
      tick(2);
      check("rsvd_no_wen", 64'(wen_cnt - w0), 64'd0);
      check("rsvd_state", 64'({config_done_o, busy_o, entries_written_o}), 64'd0);

      // bad counts
      start_load(9'd0);
      check("count0_error", 64'({error_o, error_code_o}), 64'({1'b1, 3'd5}));
      start_load(9'd257);
      check("count257_error", 64'({error_o, error_code_o, busy_o}), 64'({1'b1, 3'd5, 1'b0}));

      // byte timeout mid-entry, count 256 is legal
      start_load(9'd256);
      check("count256_ok", 64'({busy_o, error_o}), 64'b10);
      send_byte(8'hAA);
      send_byte(8'hBB);
      tick(990);
      check("timeout_not_yet", 64'(error_o), 64'd0);
      tick(15);
      check("timeout_error", 64'({error_o, error_code_o, busy_o}), 64'({1'b1, 3'd2, 1'b0}));

      // new start clears the error and loads normally
      start_load(9'd1);
      check("recover_clear", 64'({error_o, error_code_o}), 64'd0);
      send_entry(tbl[2].pkt);
      wait_flag("recover_done_seen", 1'b0);
      check("recover_config_done", 64'(config_done_o), 64'd1);

      // next_addr out of range
      w0 = wen_cnt;
      start_load(9'd4);
      send_entry(40'h00A0000000);
      check("naddr_error", 64'({error_o, error_code_o}), 64'({1'b1, 3'd4}));
      tick(2);
      check("naddr_no_wen", 64'(wen_cnt - w0), 64'd0);

      // reset during WRITE
      start_load(9'd3);
      send_entry(tbl[2].pkt);
      check("mid_write_wen", 64'(lut_wen_o), 64'd1);
      reset_i = 1'b1;
      #1;
      check("rst_mid_outputs", 64'({lut_wen_o, busy_o, config_done_o, byte_ready_o, error_o}), 64'd0);
      check("rst_mid_data", 64'({lut_write_data_o, entries_written_o}), 64'd0);
      @(posedge clk); #1;
      reset_i = 1'b0;
      tick(1);
      w0 = wen_cnt;
      start_load(9'd3);
      send_entry(tbl[2].pkt);
      send_entry(tbl[6].pkt);
      send_entry(tbl[8].pkt);
      wait_flag("fresh_done_seen", 1'b0);
      check("fresh_config_done", 64'({config_done_o, error_o}), 64'b10);
      check("fresh_wen_total", 64'(wen_cnt - w0), 64'd3);

`ifdef SEQ_LUT_VERIFY_EN
      // readback returns a corrupted word
      flip_mask = 29'h100;
      w0 = rden_cnt; t0 = srst_cnt;
      start_load(9'd2);
      send_entry(tbl[2].pkt);
      send_entry(tbl[6].pkt);
      wait_flag("verify_error_seen", 1'b1);
      check("verify_code", 64'(error_code_o), 64'd3);
      check("verify_rden_cycles", 64'(rden_cnt - w0), 64'd2);
      check("verify_seq_reset", 64'(srst_cnt - t0), 64'd1);
      check("verify_config_done", 64'(config_done_o), 64'd0);
`else
      check("no_rden", 64'(rden_cnt), 64'd0);
      check("no_seq_reset", 64'(srst_cnt), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
